// File: rtl/cci_mpf_rd_arb.sv
// Round-robin arbiter sharing the MPF C0 read request path between two clients.
// Granted requests carry the client index in mdata[TAG_BIT], which steers responses back.
module cci_mpf_rd_arb #(
  parameter int unsigned REQ_HDR_WIDTH   = 80,
  parameter int unsigned MDATA_WIDTH     = 16,
  parameter int unsigned TAG_BIT         = 15,
  parameter int unsigned DATA_WIDTH      = 512,
  parameter int unsigned FIFO_DEPTH      = 4,
  parameter int unsigned MAX_OUTSTANDING = 64
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [1:0]                    req_valid,
  input  logic [1:0][REQ_HDR_WIDTH-1:0] req_hdr,
  output logic [1:0]                    req_almfull,
  output logic [REQ_HDR_WIDTH-1:0]      C0TxHdr,
  output logic                          C0TxRdValid,
  input  logic                          c0TxAlmFull,
  input  logic                          c0_rsp_valid,
  input  logic [MDATA_WIDTH-1:0]        c0_rsp_mdata,
  input  logic [DATA_WIDTH-1:0]         c0_rsp_data,
  output logic [1:0]                    rsp_valid,
  output logic [MDATA_WIDTH-1:0]        rsp_mdata,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic                          tag_err,
  output logic                          credit_err
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned OccW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned CntW = $clog2(MAX_OUTSTANDING + 1);

  logic [REQ_HDR_WIDTH-1:0] fifoMem [2][FIFO_DEPTH];
  logic [PtrW-1:0]          wrPtr [2];
  logic [PtrW-1:0]          rdPtr [2];
  logic [OccW-1:0]          occ [2];
  logic [CntW-1:0]          outstanding [2];
  logic                     rrPrio;

  logic [1:0]               enq;
  logic [1:0]               eligible;
  logic [1:0]               grant;
  logic [1:0]               rspHit;
  logic [1:0]               rspDec;
  logic                     grantIdx;
  logic [REQ_HDR_WIDTH-1:0] grantHdr;
  logic [MDATA_WIDTH-1:0]   rspMdataClr;

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      enq[i]         = req_valid[i] && (occ[i] != OccW'(FIFO_DEPTH));
      eligible[i]    = (occ[i] != '0) && (outstanding[i] < CntW'(MAX_OUTSTANDING));
      req_almfull[i] = reset || (occ[i] >= OccW'(FIFO_DEPTH - 2));
    end
  end

  // rrPrio names the client that wins when both are eligible.
  always_comb begin
    grant = '0;
    if (!c0TxAlmFull) begin
      if (eligible[rrPrio]) begin
        grant[rrPrio] = 1'b1;
      end else if (eligible[!rrPrio]) begin
        grant[!rrPrio] = 1'b1;
      end
    end
    grantIdx          = grant[1];
    grantHdr          = fifoMem[grantIdx][rdPtr[grantIdx]];
    grantHdr[TAG_BIT] = grantIdx;
  end

  always_comb begin
    rspHit               = {c0_rsp_valid && c0_rsp_mdata[TAG_BIT],
                            c0_rsp_valid && !c0_rsp_mdata[TAG_BIT]};
    rspDec[0]            = rspHit[0] && (outstanding[0] != '0);
    rspDec[1]            = rspHit[1] && (outstanding[1] != '0);
    rspMdataClr          = c0_rsp_mdata;
    rspMdataClr[TAG_BIT] = 1'b0;
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (enq[i]) fifoMem[i][wrPtr[i]] <= req_hdr[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        wrPtr[i]       <= '0;
        rdPtr[i]       <= '0;
        occ[i]         <= '0;
        outstanding[i] <= '0;
      end
      rrPrio      <= 1'b0;
      C0TxRdValid <= 1'b0;
      C0TxHdr     <= '0;
      rsp_valid   <= '0;
      rsp_mdata   <= '0;
      rsp_data    <= '0;
      tag_err     <= 1'b0;
      credit_err  <= 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (enq[i])   wrPtr[i] <= wrPtr[i] + PtrW'(1);
        if (grant[i]) rdPtr[i] <= rdPtr[i] + PtrW'(1);
        occ[i] <= occ[i] + OccW'(enq[i]) - OccW'(grant[i]);
        // A stray response never pulls the counter below zero.
        if (grant[i] && !rspDec[i]) begin
          outstanding[i] <= outstanding[i] + CntW'(1);
        end else if (!grant[i] && rspDec[i]) begin
          outstanding[i] <= outstanding[i] - CntW'(1);
        end
        if (enq[i] && req_hdr[i][TAG_BIT]) tag_err <= 1'b1;
        if (rspHit[i] && (outstanding[i] == '0)) credit_err <= 1'b1;
      end
      C0TxRdValid <= |grant;
      if (|grant) begin
        C0TxHdr <= grantHdr;
        rrPrio  <= !grantIdx;
      end
      rsp_valid <= rspHit;
      if (c0_rsp_valid) begin
        rsp_mdata <= rspMdataClr;
        rsp_data  <= c0_rsp_data;
      end
    end
  end

  // Upstream must honour req_almfull; an enqueue into a full buffer is dropped.
  for (genvar g = 0; g < 2; g++) begin : gOvfChk
    assert property (@(posedge clk) disable iff (reset)
                     !(req_valid[g] && (occ[g] == OccW'(FIFO_DEPTH))));
  end

endmodule
